// File: rtl/interrupt_ctrl_n.sv
// Two-level prioritised interrupt controller: edge/level capture, masking,
// fixed-priority arbitration and an IDLE/REQ handshake towards the CPU.
module interrupt_ctrl_n #(
    parameter int unsigned NUM_SRC    = 5,
    parameter logic [15:0] VEC_BASE   = 16'h0003,
    parameter int unsigned VEC_STRIDE = 8,
    localparam int unsigned IDW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] int_src,
    input  logic [NUM_SRC-1:0] it_edge,
    input  logic               ie_en,
    input  logic [NUM_SRC-1:0] ie_mask,
    input  logic [NUM_SRC-1:0] ip_hi,
    input  logic               instr_boundary,
    input  logic               int_ack,
    input  logic               reti,
    output logic               int_req,
    output logic [IDW-1:0]     int_id,
    output logic [15:0]        int_vector,
    output logic [1:0]         in_service,
    output logic [NUM_SRC-1:0] pending
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [0:0]         state_q, state_nx;
    logic [NUM_SRC-1:0] src_d_q;
    logic               lvl_q, lvl_nx;
    logic               req_nx;
    logic [IDW-1:0]     id_nx;
    logic [15:0]        vec_nx;
    logic [1:0]         isv_nx;
    logic [NUM_SRC-1:0] pend_nx;

    logic [NUM_SRC-1:0] elig, elig_hi, id_onehot, ack_clr, edge_set;
    logic [IDW-1:0]     win_id;
    logic               win_hi, win_vld, win_ok, ack_go, mask_ok;

    // Arbitration: any eligible high source first, lowest index within a level
    always_comb begin
        elig    = ie_en ? (pending & ie_mask) : '0;
        elig_hi = elig & ip_hi;
        win_hi  = |elig_hi;
        win_vld = |elig;
        win_id  = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (win_hi ? elig_hi[i] : elig[i]) begin
                win_id = IDW'(i);
            end
        end
        win_ok = win_vld && (win_hi ? !in_service[1] : (in_service == 2'b00));
    end

    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            id_onehot[i] = (int_id == IDW'(i));
        end
        mask_ok = |(id_onehot & ie_mask);
        ack_go  = (state_q == ST_REQ) && int_ack;
    end

    // Pending capture; an edge arriving with the granting ack keeps the flag set
    always_comb begin
        ack_clr  = ack_go ? id_onehot : '0;
        edge_set = int_src & ~src_d_q;
        pend_nx  = (it_edge & (edge_set | (pending & ~ack_clr))) | (~it_edge & int_src);
    end

    // reti retires the innermost level before the ack adds the new one
    always_comb begin
        isv_nx = in_service;
        if (reti) begin
            if (in_service[1]) begin
                isv_nx[1] = 1'b0;
            end else begin
                isv_nx[0] = 1'b0;
            end
        end
        if (ack_go) begin
            if (lvl_q) begin
                isv_nx[1] = 1'b1;
            end else begin
                isv_nx[0] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state_q;
        req_nx   = int_req;
        id_nx    = int_id;
        vec_nx   = int_vector;
        lvl_nx   = lvl_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_boundary && win_ok) begin
                    state_nx = ST_REQ;
                    req_nx   = 1'b1;
                    id_nx    = win_id;
                    vec_nx   = 16'(32'(VEC_BASE) + 32'(win_id) * VEC_STRIDE);
                    lvl_nx   = win_hi;
                end
            end
            ST_REQ: begin
                if (int_ack || !ie_en || !mask_ok) begin
                    state_nx = ST_IDLE;
                    req_nx   = 1'b0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                req_nx   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            src_d_q    <= '0;
            lvl_q      <= 1'b0;
            int_req    <= 1'b0;
            int_id     <= '0;
            int_vector <= '0;
            in_service <= 2'b00;
            pending    <= '0;
        end else begin
            state_q    <= state_nx;
            src_d_q    <= int_src;
            lvl_q      <= lvl_nx;
            int_req    <= req_nx;
            int_id     <= id_nx;
            int_vector <= vec_nx;
            in_service <= isv_nx;
            pending    <= pend_nx;
        end
    end

endmodule

// File: tb/tb_interrupt_ctrl_n.sv
// Bench for interrupt_ctrl_n: directed scenarios plus random traffic, all
// checked each cycle against a transaction-level reference model.
module tb_interrupt_ctrl_n;

    localparam int NS = 5;
    localparam int VB = 3;
    localparam int VS = 8;

    logic          clock, reset;
    logic [NS-1:0] int_src, it_edge, ie_mask, ip_hi;
    logic          ie_en, instr_boundary, int_ack, reti;
    logic          int_req;
    logic [2:0]    int_id;
    logic [15:0]   int_vector;
    logic [1:0]    in_service;
    logic [NS-1:0] pending;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit [NS-1:0] m_pend, m_srcd;
    bit [1:0]    m_isv;
    bit          m_busy, m_lvl;
    int          m_id, m_vec;

    interrupt_ctrl_n dut (
        .clock(clock), .reset(reset), .int_src(int_src), .it_edge(it_edge),
        .ie_en(ie_en), .ie_mask(ie_mask), .ip_hi(ip_hi),
        .instr_boundary(instr_boundary), .int_ack(int_ack), .reti(reti),
        .int_req(int_req), .int_id(int_id), .int_vector(int_vector),
        .in_service(in_service), .pending(pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_pend = '0; m_srcd = '0; m_isv = 2'b00;
        m_busy = 1'b0; m_lvl = 1'b0; m_id = 0; m_vec = 0;
    endfunction

    // One clock edge of the controller as described by its rules
    function automatic void model_edge();
        int win = -1;
        bit win_hi = 1'b0;
        bit ok, ack;
        bit [1:0] isv;
        if (ie_en) begin
            for (int i = 0; i < NS; i++)
                if (m_pend[i] && ie_mask[i] && ip_hi[i]) begin win = i; win_hi = 1'b1; break; end
            if (win < 0)
                for (int i = 0; i < NS; i++)
                    if (m_pend[i] && ie_mask[i]) begin win = i; break; end
        end
        ok  = (win >= 0) && (win_hi ? (m_isv[1] == 1'b0) : (m_isv == 2'b00));
        ack = m_busy && int_ack;
        isv = m_isv;
        if (reti && isv != 2'b00) begin
            if (isv[1]) isv[1] = 1'b0; else isv[0] = 1'b0;
        end
        if (ack) isv[m_lvl ? 1 : 0] = 1'b1;
        for (int i = 0; i < NS; i++) begin
            if (it_edge[i])
                m_pend[i] = (int_src[i] && !m_srcd[i]) || (m_pend[i] && !(ack && m_id == i));
            else
                m_pend[i] = int_src[i];
        end
        if (!m_busy) begin
            if (instr_boundary && ok) begin
                m_busy = 1'b1; m_id = win; m_lvl = win_hi;
                m_vec  = (VB + win * VS) % 65536;
            end
        end else if (ack || !ie_en || !ie_mask[m_id]) begin
            m_busy = 1'b0;
        end
        m_isv  = isv;
        m_srcd = int_src;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".int_req"},    32'(int_req),    32'(m_busy));
        chk({tag, ".int_id"},     32'(int_id),     32'(m_id));
        chk({tag, ".int_vector"}, 32'(int_vector), 32'(m_vec));
        chk({tag, ".in_service"}, 32'(in_service), 32'(m_isv));
        chk({tag, ".pending"},    32'(pending),    32'(m_pend));
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_model(tag);
    endtask

    // Called at edge+1: pulse reset between clock edges
    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk({tag, ".req_drop"}, 32'(int_req), 32'd0);
        check_model(tag);
        #2 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        int_src = '0; it_edge = 5'h1f; ie_mask = 5'h1f; ip_hi = '0;
        ie_en = 1'b1; instr_boundary = 1'b1; int_ack = 1'b0; reti = 1'b0;
        model_reset();
        #1;
        chk("rst.int_req", 32'(int_req), 32'd0);
        chk("rst.int_vector", 32'(int_vector), 32'd0);
        chk("rst.in_service", 32'(in_service), 32'd0);
        chk("rst.pending", 32'(pending), 32'd0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;

        // edge src1 pulse
        int_src = 5'b00010; step("s1.pulse");
        chk("s1.pend", 32'(pending), 32'h02);
        int_src = 5'b00000; step("s1.req");
        chk("s1.req1", 32'(int_req), 32'd1);
        chk("s1.id", 32'(int_id), 32'd1);
        chk("s1.vec", 32'(int_vector), 32'h000B);
        int_ack = 1'b1; step("s1.ack");
        chk("s1.isv", 32'(in_service), 32'h1);
        chk("s1.pend_clr", 32'(pending[1]), 32'd0);
        int_ack = 1'b0; reti = 1'b1; step("s1.reti");
        reti = 1'b0;

        // high src3 beats low src1; src1 waits for reti
        ip_hi = 5'b01000; instr_boundary = 1'b0;
        int_src = 5'b01010; step("s2.pulse");
        int_src = 5'b00000; instr_boundary = 1'b1; step("s2.req");
        chk("s2.id", 32'(int_id), 32'd3);
        chk("s2.vec", 32'(int_vector), 32'h001B);
        int_ack = 1'b1; step("s2.ack");
        chk("s2.isv", 32'(in_service), 32'h2);
        int_ack = 1'b0; step("s2.wait0"); step("s2.wait1");
        chk("s2.blocked", 32'(int_req), 32'd0);
        reti = 1'b1; step("s2.reti");
        reti = 1'b0; step("s2.req_low");
        chk("s2.id_low", 32'(int_id), 32'd1);
        int_ack = 1'b1; step("s2.ack_low");
        int_ack = 1'b0; reti = 1'b1; step("s2.reti_low");
        reti = 1'b0; ip_hi = '0;

        // low src0 in service, high src2 preempts
        int_src = 5'b00001; step("s3.pulse0");
        int_src = 5'b00000; step("s3.req0");
        int_ack = 1'b1; step("s3.ack0");
        int_ack = 1'b0; ip_hi = 5'b00100;
        int_src = 5'b00100; step("s3.pulse2");
        int_src = 5'b00000; step("s3.req2");
        chk("s3.id", 32'(int_id), 32'd2);
        chk("s3.vec", 32'(int_vector), 32'h0013);
        int_ack = 1'b1; step("s3.ack2");
        chk("s3.isv11", 32'(in_service), 32'h3);
        int_ack = 1'b0; reti = 1'b1; step("s3.reti1");
        chk("s3.isv01", 32'(in_service), 32'h1);
        step("s3.reti2");
        chk("s3.isv00", 32'(in_service), 32'h0);
        reti = 1'b0; ip_hi = '0;

        // ie_en dropped while requesting
        int_src = 5'b01000; step("s4.pulse");
        int_src = 5'b00000; step("s4.req");
        ie_en = 1'b0; step("s4.abort");
        chk("s4.req0", 32'(int_req), 32'd0);
        chk("s4.pend", 32'(pending), 32'h08);
        ie_en = 1'b1; step("s4.again");
        chk("s4.req1", 32'(int_req), 32'd1);
        chk("s4.id", 32'(int_id), 32'd3);
        int_ack = 1'b1; step("s4.ack");
        int_ack = 1'b0; reti = 1'b1; step("s4.reti");
        reti = 1'b0;

        // level src4 held through ack
        it_edge = 5'b01111;
        int_src = 5'b10000; step("s5.lvl");
        step("s5.req");
        chk("s5.vec", 32'(int_vector), 32'h0023);
        int_ack = 1'b1; step("s5.ack");
        chk("s5.pend_kept", 32'(pending), 32'h10);
        int_ack = 1'b0; step("s5.idle");
        reti = 1'b1; step("s5.reti");
        chk("s5.no_req_yet", 32'(int_req), 32'd0);
        reti = 1'b0; step("s5.rereq");
        chk("s5.rereq1", 32'(int_req), 32'd1);
        int_ack = 1'b1; step("s5.ack2");
        int_ack = 1'b0; int_src = '0; reti = 1'b1; step("s5.reti2");
        reti = 1'b0; step("s5.quiet");
        reti = 1'b1; step("s5.reti_idle");
        chk("s5.isv_idle", 32'(in_service), 32'h0);
        reti = 1'b0;

        // reset during REQ, edge source held high across release
        it_edge = 5'h1f;
        int_src = 5'b00001; step("s6.pulse");
        step("s6.req");
        do_reset("s6.rst");
        step("s6.first");
        chk("s6.pend", 32'(pending), 32'h01);
        step("s6.req_again");
        chk("s6.req1", 32'(int_req), 32'd1);
        int_ack = 1'b1; step("s6.ack");
        int_ack = 1'b0; step("s6.h0"); step("s6.h1");
        chk("s6.single", 32'(int_req), 32'd0);
        reti = 1'b1; int_src = '0; step("s6.reti");
        reti = 1'b0;

        // random traffic
        for (int c = 0; c < 600; c++) begin
            if (c % 64 == 0) it_edge = 5'($urandom);
            int_src        = 5'($urandom);
            ie_mask        = ($urandom % 4 == 0) ? 5'($urandom) : 5'h1f;
            ip_hi          = 5'($urandom);
            ie_en          = ($urandom % 8) != 0;
            instr_boundary = ($urandom % 4) != 0;
            int_ack        = ($urandom % 3) == 0;
            reti           = ($urandom % 6) == 0;
            step("rnd");
            if (c == 300) do_reset("rnd.rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/interrupt_ctrl_n.md
INTERRUPT_CTRL_N -- requirements
Module: interrupt_ctrl_n

Interface
REQ-001 Parameter NUM_SRC, default 5: number of interrupt sources, 1..16.
REQ-002 Parameter VEC_BASE, default 16'h0003: vector of source 0.
REQ-003 Parameter VEC_STRIDE, default 8: vector spacing per source index.
REQ-004 Derived IDW = max(1, ceil(log2(NUM_SRC))): width of the source-index bus.
REQ-005 clock  in  1  single system clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-007 int_src  in  NUM_SRC  raw interrupt request lines.
REQ-008 it_edge  in  NUM_SRC  per-source mode: 1 = rising-edge latched, 0 = level-high.
REQ-009 ie_en  in  1  global enable (EA).
REQ-010 ie_mask  in  NUM_SRC  per-source enable.
REQ-011 ip_hi  in  NUM_SRC  per-source priority: 1 = high level, 0 = low level.
REQ-012 instr_boundary  in  1  CPU is at an instruction boundary and may be interrupted.
REQ-013 int_ack  in  1  CPU has taken the presented vector.
REQ-014 reti  in  1  CPU executed return-from-interrupt.
REQ-015 int_req  out  1  registered interrupt request to the CPU.
REQ-016 int_id  out  IDW  index of the requested source.
REQ-017 int_vector  out  16  jump address of the requested source.
REQ-018 in_service  out  2  active levels: bit 1 = high, bit 0 = low.
REQ-019 pending  out  NUM_SRC  current pending flags.

Function
REQ-020 The block SHALL register int_src into int_src_d every cycle.
REQ-021 For edge sources, pending[i] SHALL set when int_src[i]=1 and int_src_d[i]=0, and clear on an int_ack granting source i; if set and clear coincide, set wins.
REQ-022 For level sources, pending[i] SHALL equal int_src_d[i]; int_ack does not clear it.
REQ-023 eligible = pending & ie_mask, all gated by ie_en.
REQ-024 Winner selection: any eligible high source beats every low source; within one level, the lowest index wins.
REQ-025 A high winner SHALL be accepted unless in_service[1]=1; a low winner only if in_service = 2'b00.
REQ-026 FSM states: IDLE and REQ.
- IDLE->REQ on instr_boundary=1 with an acceptable winner: int_id, int_vector and the winner's level latched; int_req=1 from the next cycle.
- REQ->IDLE on int_ack; int_req=0 the next cycle.
REQ-027 In REQ, int_id and int_vector SHALL stay frozen regardless of input changes.
REQ-028 In REQ, if ie_en=0 or the latched source's ie_mask bit is 0, the FSM SHALL abort to IDLE (int_req=0 next cycle) without changing in_service or pending.
REQ-029 int_ack in IDLE SHALL be ignored.
REQ-030 On int_ack in REQ, in_service[latched level] SHALL set; high preempts an active low, both bits then set.
REQ-031 reti SHALL clear in_service[1] if set, else in_service[0]; reti with in_service=0 SHALL be ignored.
REQ-032 When reti and int_ack share a cycle, reti SHALL apply to the pre-cycle in_service, then the ack set is applied.
REQ-033 int_vector = VEC_BASE + int_id*VEC_STRIDE, truncated modulo 2^16.
REQ-034 Latency: a rising int_src first sampled at edge k sets pending at edge k; with instr_boundary=1 and the source acceptable, int_req is high after edge k+1.
REQ-035 After int_ack, the earliest new int_req rise is two edges later (one IDLE cycle).

Reset
REQ-036 On reset: FSM IDLE; int_req=0, int_id=0, int_vector=0, in_service=0, pending=0, int_src_d=0.
REQ-037 An edge source held high across reset release SHALL register one edge on the first edge after release.
REQ-038 Reset mid-REQ SHALL drop int_req immediately and lose the request; level sources re-request afterwards.

Verification
REQ-039 Bench SHALL cover, with defaults (NUM_SRC=5, VEC_BASE=0x0003, VEC_STRIDE=8):
- Edge src1 pulse, all enabled, boundary=1 -> int_req 2 edges later, int_id=1, int_vector=0x000B; ack -> in_service=01, pending[1]=0.
- Src1 and src3 pending, ip_hi[3]=1 -> int_id=3, vector 0x001B; then src1 waits until reti clears in_service.
- Low src0 in service, high src2 edge -> preempt, in_service=11; reti -> 01; reti -> 00.
- ie_en dropped while in REQ -> int_req=0 next cycle, pending unchanged; ie_en restored -> same request re-presented.
- Level src4 held high through ack -> re-request 2 edges after reti; reti with in_service=00 -> no change.
- Reset asserted during REQ -> int_req=0 without waiting for a clock; edge src held high at release -> one request.
